// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter.
// Latches a pattern, repeat count and gap option on an accepted start, then
// shifts the pattern out MSB-first, one bit per clock, for the requested
// number of repetitions. An optional single idle cycle separates repetitions.
// All outputs are registered and are derived from the next-state values, so a
// pattern bit is visible in the cycle that immediately follows the load edge.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start with reps != 0
// SEND  | driving one pattern bit per cycle
// GAP   | one idle-level cycle between repetitions
// DONE  | one-cycle completion pulse, then back to IDLE

module serial_pattern_tx #(
    parameter int   PAT_BITS   = 4,
    parameter int   CNT_BITS   = 4,
    parameter logic IDLE_VALUE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PAT_BITS-1:0] pattern,
    input  logic [CNT_BITS-1:0] reps,
    input  logic                gap_en,
    input  logic                abort,
    output logic                serial_out,
    output logic                bit_valid,
    output logic                busy,
    output logic                done
);

    localparam int BW = (PAT_BITS > 1) ? $clog2(PAT_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_BITS-1:0] shift_q, shift_d;
    logic [PAT_BITS-1:0] pat_q, pat_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_BITS-1:0] rep_cnt_q, rep_cnt_d;
    logic                gap_q, gap_d;

    logic serial_out_d, bit_valid_d, busy_d, done_d;
    logic serial_out_q, bit_valid_q, busy_q, done_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            pat_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pat_q     <= pat_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state and datapath update; abort wins over everything while busy.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pat_d     = pat_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_d     = gap_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && (reps != '0)) begin
                    pat_d     = pattern;
                    shift_d   = pattern;
                    rep_cnt_d = reps;
                    gap_d     = gap_en;
                    bit_cnt_d = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    rep_cnt_d = '0;
                end else if (bit_cnt_q != LAST_BIT) begin
                    shift_d   = {shift_q[PAT_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else begin
                    // Repetition boundary: the counter holds repetitions still
                    // owed, including the one just finished.
                    rep_cnt_d = rep_cnt_q - CNT_BITS'(1);
                    bit_cnt_d = '0;
                    if (rep_cnt_q == CNT_BITS'(1)) begin
                        state_d = S_DONE;
                        shift_d = '0;
                    end else if (gap_q) begin
                        state_d = S_GAP;
                        shift_d = '0;
                    end else begin
                        shift_d = pat_q;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    rep_cnt_d = '0;
                end else begin
                    state_d   = S_SEND;
                    shift_d   = pat_q;
                    bit_cnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so outputs can be registered
    // without adding a cycle of latency.
    always_comb begin
        serial_out_d = IDLE_VALUE;
        bit_valid_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        unique case (state_d)
            S_SEND: begin
                serial_out_d = shift_d[PAT_BITS-1];
                bit_valid_d  = 1'b1;
                busy_d       = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                serial_out_d = IDLE_VALUE;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_out_q <= IDLE_VALUE;
            bit_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            serial_out_q <= serial_out_d;
            bit_valid_q  <= bit_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign serial_out = serial_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial pattern transmitter: the driving end for the serial sequence-detector path.
- Latches a PAT_BITS-wide pattern and repeat count on start, then shifts the pattern out MSB-first, one bit per clk, for the requested number of repetitions.
- An optional one-bit idle gap can be inserted between repetitions.
- Feeds the 1-bit serial input of the sequence detector, either in the bench or as an on-chip self-test source.

Parameters:
- PAT_BITS, 4, pattern width in bits (>=2).
- CNT_BITS, 4, repeat-count width.
- IDLE_VALUE, 1'b0, serial_out level whenever no pattern bit is driven.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- pattern  input  PAT_BITS  pattern to send, MSB transmitted first; latched on accepted start.
- reps  input  CNT_BITS  number of transmissions; latched on accepted start.
- gap_en  input  1  1 = one IDLE_VALUE cycle between repetitions; latched on accepted start.
- abort  input  1  cancel transmission in progress.
- serial_out  output  1  registered serial data.
- bit_valid  output  1  registered; 1 when serial_out carries a pattern bit.
- busy  output  1  registered; 1 in SEND and GAP.
- done  output  1  registered single-cycle completion pulse.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE immediately, regardless of clk.
  - serial_out=IDLE_VALUE; bit_valid=0, busy=0, done=0.
  - Shift register, bit counter and repeat counter are cleared.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Start is accepted when start=1 and reps!=0 at a rising edge.
  - On acceptance, at that edge: latch pattern, reps and gap_en; load shift register; go to SEND.
  - After that edge: serial_out=pattern[PAT_BITS-1], bit_valid=1, busy=1 (zero-cycle latency from the accepting edge).
  - start=1 with reps==0 is ignored: no busy, no done.
- SEND:
  - Each edge shifts the next bit out.
  - Bit k of a repetition (k=0..PAT_BITS-1) is visible during cycle k after the repetition's load edge.
  - After the final bit, with repetitions remaining:
    - gap_en=1: go to GAP.
    - gap_en=0: reload the latched pattern and continue SEND back-to-back; the MSB directly follows the LSB.
  - After the final bit of the final repetition: go to DONE.
- GAP:
  - Exactly one cycle: serial_out=IDLE_VALUE, bit_valid=0, busy=1.
  - Then reload the latched pattern and return to SEND.
- DONE:
  - One cycle: done=1, busy=0, bit_valid=0, serial_out=IDLE_VALUE.
  - Then go to IDLE unconditionally.
  - start during DONE is ignored.
- The latched pattern is the source for every repetition. Changes on pattern, reps or gap_en while busy have no effect.
- start while busy is ignored; it is not queued.
- abort:
  - Sampled in SEND or GAP.
  - Next state is IDLE: serial_out=IDLE_VALUE, busy=0, bit_valid=0, no done pulse.
  - abort in IDLE or DONE has no effect.
  - abort and start both high in IDLE: start is accepted, abort is ignored.
- Repeat counter:
  - Loaded with reps and decremented at each repetition end.
  - Maximum reps=2^CNT_BITS-1; no wrap occurs because reps==0 is never accepted.
- Total busy cycles = reps*PAT_BITS + (gap_en ? reps-1 : 0).
- done asserts on the cycle after the last busy cycle.

Test Plan:
- Reset: rst=1 mid-cycle, asynchronously, with no clk edge -> serial_out=0, busy=0, done=0, bit_valid=0 immediately; all hold for 2 cycles after rst=0 with start=0.
- Single send: pattern=4'b1101, reps=1, start pulse -> serial_out 1,1,0,1 with bit_valid=1 on cycles 0-3 after the accepting edge; done=1 on cycle 4 only; busy=0 from cycle 4.
- Gapped repeat: pattern=4'b1101, reps=2, gap_en=1 -> serial_out 1,1,0,1,0,1,1,0,1; bit_valid low only on cycle 4; done on cycle 9. Looped into the 1101 detector, its output goes high after bits 3 and 8.
- Back-to-back repeat: pattern=4'b1101, reps=3, gap_en=0 -> 12 contiguous bits 110111011101, busy high 12 cycles, done on cycle 12. Drive pattern=4'b0000 and start=1 during cycles 2-5 -> stream unchanged.
- Abort and mid-operation reset: abort=1 on cycle 2 of pattern 1101 -> serial_out=0, busy=0 next cycle, done never asserts. Separately, rst=1 on cycle 1 -> immediate idle outputs; a fresh start afterwards sends the full 1101.
- Edge inputs: start with reps=0 -> busy stays 0, no done. start held high continuously with reps=1 -> new transmission begins on the cycle after each done pulse, never during it.
